// File: rtl/traffic_light_safety_monitor_if.sv
// Signal bundle between the light controller, the safety monitor and the lamp drivers.
// The master side is the controller plus lamp readback; the slave side is the monitor.
interface traffic_light_safety_monitor_if;
    logic       red_in;
    logic       yellow_in;
    logic       green_in;
    logic       fault_clr;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;
    logic       fault;
    logic [2:0] fault_code;

    modport master (
        output red_in, yellow_in, green_in, fault_clr,
        input  lamp_red, lamp_yellow, lamp_green, fault, fault_code
    );

    modport slave (
        input  red_in, yellow_in, green_in, fault_clr,
        output lamp_red, lamp_yellow, lamp_green, fault, fault_code
    );
endinterface

// File: rtl/traffic_light_safety_monitor.sv
// Passes legal red/yellow/green sequences to the lamps and traps encoding, order and
// dwell violations into a sticky fault with fail-safe flashing red.
module traffic_light_safety_monitor #(
    parameter int RED_MIN    = 3,
    parameter int RED_MAX    = 20,
    parameter int YEL_MIN    = 1,
    parameter int YEL_MAX    = 8,
    parameter int GRN_MIN    = 3,
    parameter int GRN_MAX    = 20,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic rst,
    traffic_light_safety_monitor_if.slave bus
);
    typedef enum logic [1:0] {ST_INIT, ST_MONITOR, ST_FAULT} state_t;
    typedef enum logic [2:0] {
        FC_NONE        = 3'd0,
        FC_NOT_ONE_HOT = 3'd1,
        FC_ILLEGAL     = 3'd2,
        FC_EARLY       = 3'd3,
        FC_OVERRUN     = 3'd4
    } fault_code_t;

    // Patterns are packed {red, yellow, green}
    localparam logic [2:0]       PAT_R   = 3'b100;
    localparam logic [2:0]       PAT_Y   = 3'b010;
    localparam logic [2:0]       PAT_G   = 3'b001;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLASH_N = CNT_W'(FLASH_HALF);

    logic [2:0]       r_pat;
    state_t           state;
    logic [2:0]       lamp_q;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] flash_cnt;
    logic             first_phase;
    logic             fault_q;
    fault_code_t      code_q;

    logic             one_hot;
    logic             same;
    logic             legal_step;
    logic [CNT_W-1:0] cur_min;
    logic [CNT_W-1:0] cur_max;
    logic [CNT_W-1:0] dwell_inc;
    fault_code_t      check_code;

    // NOTE: every register is written with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pat <= '0;
        else     r_pat <= {bus.red_in, bus.yellow_in, bus.green_in};
    end

    // In MONITOR lamp_q holds the colour currently being timed.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        cur_min    = CNT_W'(RED_MIN);
        cur_max    = CNT_W'(RED_MAX);
        check_code = FC_NONE;
        if (lamp_q == PAT_Y) begin
            cur_min = CNT_W'(YEL_MIN);
            cur_max = CNT_W'(YEL_MAX);
        end else if (lamp_q == PAT_G) begin
            cur_min = CNT_W'(GRN_MIN);
            cur_max = CNT_W'(GRN_MAX);
        end
        one_hot    = (r_pat == PAT_R) || (r_pat == PAT_Y) || (r_pat == PAT_G);
        same       = (r_pat == lamp_q);
        legal_step = (lamp_q == PAT_G && r_pat == PAT_Y) ||
                     (lamp_q == PAT_Y && r_pat == PAT_R) ||
                     (lamp_q == PAT_R && r_pat == PAT_G);
        dwell_inc  = dwell + CNT_ONE;

        if (!one_hot)                                   check_code = FC_NOT_ONE_HOT;
        else if (!same && !legal_step)                  check_code = FC_ILLEGAL;
        else if (!same && !first_phase && dwell < cur_min) check_code = FC_EARLY;
        else if (same && dwell_inc > cur_max)           check_code = FC_OVERRUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            lamp_q      <= PAT_R;
            dwell       <= '0;
            flash_cnt   <= '0;
            first_phase <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
        end else begin
            case (state)
                ST_INIT: begin
                    if (one_hot) begin
                        state       <= ST_MONITOR;
                        lamp_q      <= r_pat;
                        dwell       <= CNT_ONE;
                        first_phase <= 1'b1;
                    end else begin
                        lamp_q <= PAT_R;
                    end
                end
                ST_MONITOR: begin
                    if (check_code != FC_NONE) begin
                        state     <= ST_FAULT;
                        fault_q   <= 1'b1;
                        code_q    <= check_code;
                        lamp_q    <= PAT_R;
                        flash_cnt <= CNT_ONE;
                    end else begin
                        lamp_q <= r_pat;
                        if (!same) begin
                            dwell       <= CNT_ONE;
                            first_phase <= 1'b0;
                        end else if (dwell <= cur_max) begin
                            // Saturates at MAX+1 so the counter can never wrap
                            dwell <= dwell_inc;
                        end
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr) begin
                        state       <= ST_INIT;
                        lamp_q      <= PAT_R;
                        fault_q     <= 1'b0;
                        code_q      <= FC_NONE;
                        flash_cnt   <= '0;
                        dwell       <= '0;
                        first_phase <= 1'b0;
                    end else if (flash_cnt >= FLASH_N) begin
                        lamp_q    <= {~lamp_q[2], 2'b00};
                        flash_cnt <= CNT_ONE;
                    end else begin
                        flash_cnt <= flash_cnt + CNT_ONE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.lamp_red    = lamp_q[2];
    assign bus.lamp_yellow = lamp_q[1];
    assign bus.lamp_green  = lamp_q[0];
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
endmodule
